// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register index width,
// the operand forward-select encoding (also consumed by debug/trace) and a
// helper that picks the forwarding source from the bypass match flags.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

  // Youngest producer wins: EX, then MEM, then WB, else the register array.
  function automatic fwd_sel_e fwd_select(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic wb_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Output bundle from the operand fetch stage register to EX.
// Handshake: the stage holds an instruction while OF_VALID is high; it is
// consumed on any rising edge where OF_VALID && EX_READY. While OF_VALID is
// high and EX_READY is low every OF_* field stays stable.
interface operand_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic                           OF_VALID;
  logic                           EX_READY;
  logic [31:0]                    OF_PC;
  logic [XLEN-1:0]                OF_RS1_DATA;
  logic [XLEN-1:0]                OF_RS2_DATA;
  logic [riscv_pkg::REG_IDX_W-1:0] OF_RD;
  logic                           OF_RD_WEN;
  logic                           OF_IS_LOAD;

  modport master (
    output OF_VALID, OF_PC, OF_RS1_DATA, OF_RS2_DATA, OF_RD, OF_RD_WEN, OF_IS_LOAD,
    input  EX_READY
  );

  modport slave (
    input  OF_VALID, OF_PC, OF_RS1_DATA, OF_RS2_DATA, OF_RD, OF_RD_WEN, OF_IS_LOAD,
    output EX_READY
  );
endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// of_scoreboard: one pending bit per x1..x31 for loads in flight.
// x0 never becomes pending. When set and clear target the same register in
// the same cycle the set wins, since the newly issued load is the younger one.
module of_scoreboard
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_set_en,
  input  reg_idx_t i_set_idx,
  input  logic     i_clr_en,
  input  reg_idx_t i_clr_idx,
  input  reg_idx_t i_lk1_idx,
  input  reg_idx_t i_lk2_idx,
  input  reg_idx_t i_waw_idx,
  output logic     o_lk1_pend,
  output logic     o_lk2_pend,
  output logic     o_waw_pend
);

  logic [NUM_REGS-1:0] r_pending;

  // Pending-bit update with set priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set_en && (i_set_idx == reg_idx_t'(i)))
          r_pending[i] <= 1'b1;
        else if (i_clr_en && (i_clr_idx == reg_idx_t'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

  assign o_lk1_pend = r_pending[i_lk1_idx];
  assign o_lk2_pend = r_pending[i_lk2_idx];
  assign o_waw_pend = r_pending[i_waw_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: resolves source operands from EX/MEM/WB bypasses or
// the register array, stalls decode on load-use, back-to-back RAW and load
// WAW hazards, and holds one instruction for EX behind valid/ready.
// Optional feature macro: RISCV_WB_BYPASS_EN enables the writeback bypass;
// without it a source matching the writeback port waits one cycle and is
// then read from the (already written) register array.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ID_VALID,
  output logic            OF_READY,
  input  logic [31:0]     ID_PC,
  input  reg_idx_t        ID_RS1,
  input  reg_idx_t        ID_RS2,
  input  logic            ID_RS1_USED,
  input  logic            ID_RS2_USED,
  input  reg_idx_t        ID_RD,
  input  logic            ID_RD_WEN,
  input  logic            ID_IS_LOAD,
  output reg_idx_t        RS1_SEL,
  output reg_idx_t        RS2_SEL,
  input  logic [XLEN-1:0] RS1_DATAOUT,
  input  logic [XLEN-1:0] RS2_DATAOUT,
  input  logic            EX_FWD_VALID,
  input  reg_idx_t        EX_FWD_RD,
  input  logic [XLEN-1:0] EX_FWD_DATA,
  input  logic            MEM_FWD_VALID,
  input  reg_idx_t        MEM_FWD_RD,
  input  logic [XLEN-1:0] MEM_FWD_DATA,
  input  logic            RD_WB_VALID_MEM3_WB,
  input  reg_idx_t        RD_WB_MEM3_WB,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic            FLUSH,
  operand_fetch_stage_if.master ex_if
);

`ifdef RISCV_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  logic            r_of_valid;
  logic [31:0]     r_of_pc;
  logic [XLEN-1:0] r_of_rs1_data;
  logic [XLEN-1:0] r_of_rs2_data;
  reg_idx_t        r_of_rd;
  logic            r_of_rd_wen;
  logic            r_of_is_load;

  logic            w_pend1, w_pend2, w_waw_pend;
  logic            w_wb_hit1, w_wb_hit2;
  fwd_sel_e        w_rs1_sel, w_rs2_sel;
  logic [XLEN-1:0] w_rs1_op, w_rs2_op;
  logic            w_blk1, w_blk2, w_waw, w_hazard;
  logic            w_accept, w_issue, w_sb_set, w_sb_clr;

  assign RS1_SEL = ID_RS1;
  assign RS2_SEL = ID_RS2;

  assign w_wb_hit1 = RD_WB_VALID_MEM3_WB && (RD_WB_MEM3_WB == ID_RS1);
  assign w_wb_hit2 = RD_WB_VALID_MEM3_WB && (RD_WB_MEM3_WB == ID_RS2);

  // Operand select and mux; x0 and unused sources always capture zero.
  always_comb begin
    w_rs1_sel = fwd_select(EX_FWD_VALID  && (EX_FWD_RD  == ID_RS1),
                           MEM_FWD_VALID && (MEM_FWD_RD == ID_RS1),
                           WB_BYPASS && w_wb_hit1);
    w_rs2_sel = fwd_select(EX_FWD_VALID  && (EX_FWD_RD  == ID_RS2),
                           MEM_FWD_VALID && (MEM_FWD_RD == ID_RS2),
                           WB_BYPASS && w_wb_hit2);
    case (w_rs1_sel)
      FWD_EX:  w_rs1_op = EX_FWD_DATA;
      FWD_MEM: w_rs1_op = MEM_FWD_DATA;
      FWD_WB:  w_rs1_op = WB_DATA;
      default: w_rs1_op = RS1_DATAOUT;
    endcase
    case (w_rs2_sel)
      FWD_EX:  w_rs2_op = EX_FWD_DATA;
      FWD_MEM: w_rs2_op = MEM_FWD_DATA;
      FWD_WB:  w_rs2_op = WB_DATA;
      default: w_rs2_op = RS2_DATAOUT;
    endcase
    if (!ID_RS1_USED || (ID_RS1 == '0)) w_rs1_op = '0;
    if (!ID_RS2_USED || (ID_RS2 == '0)) w_rs2_op = '0;
  end

  // Hazard detection and the decode-side ready.
  always_comb begin
    w_blk1 = ID_RS1_USED && (ID_RS1 != '0) &&
             ((w_pend1 && !(WB_BYPASS && w_wb_hit1)) ||
              (r_of_valid && r_of_rd_wen && (r_of_rd == ID_RS1)) ||
              (!WB_BYPASS && w_wb_hit1));
    w_blk2 = ID_RS2_USED && (ID_RS2 != '0) &&
             ((w_pend2 && !(WB_BYPASS && w_wb_hit2)) ||
              (r_of_valid && r_of_rd_wen && (r_of_rd == ID_RS2)) ||
              (!WB_BYPASS && w_wb_hit2));
    w_waw    = ID_IS_LOAD &&
               (w_waw_pend || (r_of_valid && r_of_is_load && (r_of_rd == ID_RD)));
    w_hazard = ID_VALID && (w_blk1 || w_blk2 || w_waw);
    OF_READY = !FLUSH && !w_hazard && (!r_of_valid || ex_if.EX_READY);
    w_accept = ID_VALID && OF_READY;
    w_issue  = r_of_valid && ex_if.EX_READY && !FLUSH;
    w_sb_set = w_issue && r_of_is_load && r_of_rd_wen && (r_of_rd != '0);
    w_sb_clr = RD_WB_VALID_MEM3_WB && (RD_WB_MEM3_WB != '0);
  end

  of_scoreboard u_scoreboard (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_set_en   (w_sb_set),
    .i_set_idx  (r_of_rd),
    .i_clr_en   (w_sb_clr),
    .i_clr_idx  (RD_WB_MEM3_WB),
    .i_lk1_idx  (ID_RS1),
    .i_lk2_idx  (ID_RS2),
    .i_waw_idx  (ID_RD),
    .o_lk1_pend (w_pend1),
    .o_lk2_pend (w_pend2),
    .o_waw_pend (w_waw_pend)
  );

  // Output register: flush kills, accept loads, issue alone drains.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_of_valid    <= 1'b0;
      r_of_pc       <= '0;
      r_of_rs1_data <= '0;
      r_of_rs2_data <= '0;
      r_of_rd       <= '0;
      r_of_rd_wen   <= 1'b0;
      r_of_is_load  <= 1'b0;
    end else if (FLUSH) begin
      r_of_valid <= 1'b0;
    end else if (w_accept) begin
      r_of_valid    <= 1'b1;
      r_of_pc       <= ID_PC;
      r_of_rs1_data <= w_rs1_op;
      r_of_rs2_data <= w_rs2_op;
      r_of_rd       <= ID_RD;
      r_of_rd_wen   <= ID_RD_WEN;
      r_of_is_load  <= ID_IS_LOAD;
    end else if (w_issue) begin
      r_of_valid <= 1'b0;
    end
  end

  assign ex_if.OF_VALID    = r_of_valid;
  assign ex_if.OF_PC       = r_of_pc;
  assign ex_if.OF_RS1_DATA = r_of_rs1_data;
  assign ex_if.OF_RS2_DATA = r_of_rs2_data;
  assign ex_if.OF_RD       = r_of_rd;
  assign ex_if.OF_RD_WEN   = r_of_rd_wen;
  assign ex_if.OF_IS_LOAD  = r_of_is_load;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model of the stage.
module tb_operand_fetch_stage;

`ifdef RISCV_WB_BYPASS_EN
  localparam bit HAS_WB = 1'b1;
`else
  localparam bit HAS_WB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        ID_VALID, ID_RS1_USED, ID_RS2_USED, ID_RD_WEN, ID_IS_LOAD;
  logic [31:0] ID_PC;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD, RS1_SEL, RS2_SEL;
  logic [31:0] RS1_DATAOUT, RS2_DATAOUT;
  logic        EX_FWD_VALID, MEM_FWD_VALID, RD_WB_VALID_MEM3_WB, FLUSH, OF_READY;
  logic [4:0]  EX_FWD_RD, MEM_FWD_RD, RD_WB_MEM3_WB;
  logic [31:0] EX_FWD_DATA, MEM_FWD_DATA, WB_DATA;

  operand_fetch_stage_if #(.XLEN(32)) ex_bus();

  // Register array model, read through the DUT's selects.
  logic [31:0] rf [32];
  assign RS1_DATAOUT = rf[RS1_SEL];
  assign RS2_DATAOUT = rf[RS2_SEL];

  operand_fetch_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .OF_READY(OF_READY),
    .ID_PC(ID_PC), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .ID_RD(ID_RD), .ID_RD_WEN(ID_RD_WEN), .ID_IS_LOAD(ID_IS_LOAD),
    .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL),
    .RS1_DATAOUT(RS1_DATAOUT), .RS2_DATAOUT(RS2_DATAOUT),
    .EX_FWD_VALID(EX_FWD_VALID), .EX_FWD_RD(EX_FWD_RD), .EX_FWD_DATA(EX_FWD_DATA),
    .MEM_FWD_VALID(MEM_FWD_VALID), .MEM_FWD_RD(MEM_FWD_RD), .MEM_FWD_DATA(MEM_FWD_DATA),
    .RD_WB_VALID_MEM3_WB(RD_WB_VALID_MEM3_WB), .RD_WB_MEM3_WB(RD_WB_MEM3_WB),
    .WB_DATA(WB_DATA), .FLUSH(FLUSH), .ex_if(ex_bus)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic        last_ready;
  logic [31:0] pc_ctr = 32'h1000;

  bit          m_valid, m_wen, m_load;
  logic [31:0] m_pc, m_d1, m_d2;
  logic [4:0]  m_rd;
  bit          m_pend [32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Value the stage should capture for a source, from the forwarding rules.
  function automatic logic [31:0] resolve(input logic [4:0] s, input logic u);
    if (!u || s == 0) return 32'h0;
    if (EX_FWD_VALID && EX_FWD_RD == s) return EX_FWD_DATA;
    if (MEM_FWD_VALID && MEM_FWD_RD == s) return MEM_FWD_DATA;
    if (HAS_WB && RD_WB_VALID_MEM3_WB && RD_WB_MEM3_WB == s) return WB_DATA;
    return rf[s];
  endfunction

  // Whether a source cannot be supplied this cycle.
  function automatic bit blocked(input logic [4:0] s, input logic u);
    bit wbh;
    wbh = RD_WB_VALID_MEM3_WB && (RD_WB_MEM3_WB == s);
    if (!u || s == 0) return 1'b0;
    if (m_valid && m_wen && m_rd == s) return 1'b1;
    if (HAS_WB) return m_pend[s] && !wbh;
    return m_pend[s] || wbh;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, ex_bus.OF_VALID,    m_valid);
    check_eq({tag, "_pc"},    ex_bus.OF_PC,       m_pc);
    check_eq({tag, "_rs1d"},  ex_bus.OF_RS1_DATA, m_d1);
    check_eq({tag, "_rs2d"},  ex_bus.OF_RS2_DATA, m_d2);
    check_eq({tag, "_rd"},    ex_bus.OF_RD,       m_rd);
    check_eq({tag, "_wen"},   ex_bus.OF_RD_WEN,   m_wen);
    check_eq({tag, "_load"},  ex_bus.OF_IS_LOAD,  m_load);
  endtask

  // One clock: entered just after a negedge with inputs already driven.
  task automatic run_cycle();
    logic [31:0] op1, op2, wbd;
    logic [4:0]  wbr;
    bit hz, rdy, acc, iss, wbv, fl;
    #1;
    op1 = resolve(ID_RS1, ID_RS1_USED);
    op2 = resolve(ID_RS2, ID_RS2_USED);
    hz  = ID_VALID && (blocked(ID_RS1, ID_RS1_USED) || blocked(ID_RS2, ID_RS2_USED) ||
          (ID_IS_LOAD && (m_pend[ID_RD] || (m_valid && m_load && m_rd == ID_RD))));
    rdy = !FLUSH && !hz && (!m_valid || ex_bus.EX_READY);
    check_eq("of_ready", OF_READY, rdy);
    check_eq("rs1_sel", RS1_SEL, ID_RS1);
    check_eq("rs2_sel", RS2_SEL, ID_RS2);
    last_ready = OF_READY;
    acc = ID_VALID && rdy;
    iss = m_valid && ex_bus.EX_READY && !FLUSH;
    wbv = RD_WB_VALID_MEM3_WB; wbr = RD_WB_MEM3_WB; wbd = WB_DATA; fl = FLUSH;
    @(posedge CLK);
    #1;
    if (wbv && wbr != 0) begin m_pend[wbr] = 1'b0; rf[wbr] = wbd; end
    if (iss && m_load && m_wen && m_rd != 0) m_pend[m_rd] = 1'b1;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_pc = ID_PC; m_d1 = op1; m_d2 = op2;
      m_rd = ID_RD; m_wen = ID_RD_WEN; m_load = ID_IS_LOAD;
    end else if (iss) m_valid = 1'b0;
    check_outputs("of");
    @(negedge CLK);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ID_VALID = 0; ID_PC = 0; ID_RS1 = 0; ID_RS2 = 0; ID_RS1_USED = 0; ID_RS2_USED = 0;
    ID_RD = 0; ID_RD_WEN = 0; ID_IS_LOAD = 0;
    EX_FWD_VALID = 0; EX_FWD_RD = 0; EX_FWD_DATA = 0;
    MEM_FWD_VALID = 0; MEM_FWD_RD = 0; MEM_FWD_DATA = 0;
    RD_WB_VALID_MEM3_WB = 0; RD_WB_MEM3_WB = 0; WB_DATA = 0;
    FLUSH = 0; ex_bus.EX_READY = 1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wen, input logic ld);
    ID_VALID = 1; ID_PC = pc_ctr; pc_ctr = pc_ctr + 4;
    ID_RS1 = rs1; ID_RS1_USED = u1; ID_RS2 = rs2; ID_RS2_USED = u2;
    ID_RD = rd; ID_RD_WEN = wen; ID_IS_LOAD = ld;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] d);
    RD_WB_VALID_MEM3_WB = 1; RD_WB_MEM3_WB = rd; WB_DATA = d;
  endtask

  task automatic do_reset();
    #3 RST_N = 0;
    #1;
    m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_wen = 0; m_load = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    check_outputs("reset");
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    RST_N = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] pq [$];
    idle_inputs();
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    do_reset();
    run_cycle();
    check_eq("reset_ready", last_ready, 1'b1);

    // Independent ALU ops back to back.
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd6, 1, 0); run_cycle();
    check_eq("t1_acc0", last_ready, 1'b1);
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd5, 1, 0); run_cycle();
    check_eq("t1_acc1", last_ready, 1'b1);

    // Dependent op behind its producer: one bubble, then EX forward.
    idle_inputs(); set_id(5'd5, 1, 5'd6, 1, 5'd7, 1, 0); run_cycle();
    check_eq("t2_bubble", last_ready, 1'b0);
    idle_inputs(); set_id(5'd5, 1, 5'd6, 1, 5'd7, 1, 0);
    EX_FWD_VALID = 1; EX_FWD_RD = 5'd5; EX_FWD_DATA = 32'h11; run_cycle();
    check_eq("t2_accept", last_ready, 1'b1);
    check_eq("t2_exfwd", ex_bus.OF_RS1_DATA, 32'h11);

    // Load-use.
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd8, 1, 1); run_cycle();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); set_id(5'd8, 1, 5'd0, 1, 5'd9, 1, 0); run_cycle();
      check_eq("t3_stall", last_ready, 1'b0);
    end
    idle_inputs(); set_id(5'd8, 1, 5'd0, 1, 5'd9, 1, 0); set_wb(5'd8, 32'hDEADBEEF); run_cycle();
    check_eq("t3_wb_cycle", last_ready, HAS_WB);
    if (!HAS_WB) begin
      idle_inputs(); set_id(5'd8, 1, 5'd0, 1, 5'd9, 1, 0); run_cycle();
      check_eq("t3_after_wb", last_ready, 1'b1);
    end
    check_eq("t3_data", ex_bus.OF_RS1_DATA, 32'hDEADBEEF);

    // Forward priority, and x0 ignoring every path.
    idle_inputs(); set_id(5'd10, 1, 5'd0, 1, 5'd15, 1, 0);
    EX_FWD_VALID = 1; EX_FWD_RD = 5'd10; EX_FWD_DATA = 32'd1;
    MEM_FWD_VALID = 1; MEM_FWD_RD = 5'd10; MEM_FWD_DATA = 32'd2;
    if (HAS_WB) set_wb(5'd10, 32'd3);
    run_cycle();
    check_eq("t4_prio", ex_bus.OF_RS1_DATA, 32'd1);
    idle_inputs(); set_id(5'd0, 1, 5'd0, 1, 5'd16, 1, 0);
    EX_FWD_VALID = 1; EX_FWD_RD = 5'd0; EX_FWD_DATA = 32'd5;
    MEM_FWD_VALID = 1; MEM_FWD_RD = 5'd0; MEM_FWD_DATA = 32'd6;
    set_wb(5'd0, 32'd7); run_cycle();
    check_eq("t4_x0_rs1", ex_bus.OF_RS1_DATA, 32'd0);
    check_eq("t4_x0_rs2", ex_bus.OF_RS2_DATA, 32'd0);

    // Flush of a load in the output register.
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd11, 1, 1); run_cycle();
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd13, 1, 0); FLUSH = 1; run_cycle();
    check_eq("t5_no_accept", last_ready, 1'b0);
    check_eq("t5_killed", ex_bus.OF_VALID, 1'b0);
    idle_inputs(); set_id(5'd11, 1, 5'd0, 0, 5'd14, 1, 0); run_cycle();
    check_eq("t5_x11_clear", last_ready, 1'b1);

    // Set wins over clear, then WAW hold on a pending rd.
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd12, 1, 1); run_cycle();
    idle_inputs(); set_wb(5'd12, 32'h1234); run_cycle();
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd12, 1, 1); run_cycle();
    check_eq("t6_waw_held", last_ready, 1'b0);
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd12, 1, 1); set_wb(5'd12, 32'h5678); run_cycle();
    check_eq("t6_waw_wb", last_ready, 1'b0);
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd12, 1, 1); run_cycle();
    check_eq("t6_waw_free", last_ready, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0)
        set_id(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        EX_FWD_VALID = 1; EX_FWD_RD = 5'($urandom_range(0, 7)); EX_FWD_DATA = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        MEM_FWD_VALID = 1; MEM_FWD_RD = 5'($urandom_range(0, 7)); MEM_FWD_DATA = $urandom;
      end
      pq.delete();
      for (int i = 1; i < 32; i++) if (m_pend[i]) pq.push_back(5'(i));
      if (pq.size() != 0 && $urandom_range(0, 1) == 1)
        set_wb(pq[$urandom_range(0, pq.size() - 1)], $urandom);
      else if ($urandom_range(0, 3) == 0)
        set_wb(5'($urandom_range(0, 7)), $urandom);
      ex_bus.EX_READY = ($urandom_range(0, 3) != 0);
      FLUSH = ($urandom_range(0, 15) == 0);
      run_cycle();
    end

    // Reset in the middle of traffic forgets all pending loads.
    do_reset();
    idle_inputs(); set_id(5'd0, 1, 5'd0, 0, 5'd8, 1, 1); run_cycle();
    idle_inputs(); run_cycle();
    do_reset();
    idle_inputs(); set_id(5'd8, 1, 5'd0, 0, 5'd9, 1, 0); run_cycle();
    check_eq("rst_forgets", last_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
